// File: rtl/clkdiv_prog.sv
// Programmable multi-channel clock divider with 50% duty, glitch-free reload.
// Ports: clk, rst (sync, active-high), en/load per channel, div_in packed
// divisors, out divided clocks, tick one-cycle pulse after each out rise.
module clkdiv_prog #(
  parameter int CH       = 2,
  parameter int WIDTH    = 8,
  parameter int DIV_INIT = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         en,
  input  logic [CH*WIDTH-1:0]   div_in,
  input  logic [CH-1:0]         load,
  output logic [CH-1:0]         out,
  output logic [CH-1:0]         tick
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [WIDTH-1:0] DRAW  = WIDTH'(DIV_INIT);
  localparam logic [WIDTH-1:0] DINIT =
    (DRAW < WIDTH'(2)) ? WIDTH'(2) : DRAW;

  function automatic logic [WIDTH-1:0] clamp(
    input logic [WIDTH-1:0] v
  );
    return (v < WIDTH'(2)) ? WIDTH'(2) : v;
  endfunction

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           st, st_n;
    logic [WIDTH-1:0] d, d_n;
    logic [WIDTH-1:0] p, p_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] din;
    logic             pend, pend_n;
    logic             bound;
    logic             ph, ph_n;
    logic             trim, trim_n;
    logic             ntrim;
    logic             tk, tk_n;
    logic [WIDTH:0]   half;

    assign din = clamp(div_in[i*WIDTH +: WIDTH]);

    always_comb begin
      st_n   = st;
      d_n    = d;
      p_n    = p;
      pend_n = pend;
      cnt_n  = cnt;
      bound  = (st == ST_RUN) && (cnt == d - 1'b1);
      unique case (st)
        ST_IDLE: begin
          if (load[i]) d_n = din;
          if (en[i]) begin
            st_n  = ST_RUN;
            cnt_n = '0;
          end
        end
        ST_RUN: begin
          if (bound) begin
            cnt_n = '0;
            // a load landing on the boundary wins over an older pending value
            if (load[i]) begin
              d_n    = din;
              pend_n = 1'b0;
            end else if (pend) begin
              d_n    = p;
              pend_n = 1'b0;
            end
            if (!en[i]) st_n = ST_IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
            if (load[i]) begin
              p_n    = din;
              pend_n = 1'b1;
            end
          end
        end
      endcase
      // ph is high for ceil(D/2) cycles; for odd D the last of those
      // cycles is cut in half by the negedge copy of trim
      half   = ({1'b0, d_n} + 1'b1) >> 1;
      ph_n   = (st_n == ST_RUN) && ({1'b0, cnt_n} < half);
      trim_n = (st_n == ST_RUN) && d_n[0] &&
               ({1'b0, cnt_n} == half - 1'b1);
      tk_n   = (st == ST_RUN) && (cnt == '0);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= ST_IDLE;
        d    <= DINIT;
        p    <= DINIT;
        pend <= 1'b0;
        cnt  <= '0;
        ph   <= 1'b0;
        trim <= 1'b0;
        tk   <= 1'b0;
      end else begin
        st   <= st_n;
        d    <= d_n;
        p    <= p_n;
        pend <= pend_n;
        cnt  <= cnt_n;
        ph   <= ph_n;
        trim <= trim_n;
        tk   <= tk_n;
      end
    end

    // trim is cleared by reset, so this copy clears on the next negedge
    always_ff @(negedge clk) begin
      ntrim <= trim;
    end

    assign out[i]  = ph & ~ntrim;
    assign tick[i] = tk;
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog: directed scenarios then random traffic
// against a half-cycle-resolution period model.
module tb_clkdiv_prog;
  localparam int CH = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] div_in;
  logic [CH-1:0]   load;
  logic [CH-1:0]   out;
  logic [CH-1:0]   tick;

  int checks   = 0;
  int failures = 0;

  int md   [CH];
  int mp   [CH];
  bit mpend[CH];
  bit mrun [CH];
  int mpos [CH];
  bit mtick[CH];

  clkdiv_prog #(.CH(CH), .WIDTH(W), .DIV_INIT(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .div_in(div_in),
    .load  (load),
    .out   (out),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Period-level model: position within the current period, with D
  // changes only taking effect at a period start.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int v;
      v = int'(div_in[c*W +: W]);
      mtick[c] = !rst && mrun[c] && (mpos[c] == 0);
      if (rst) begin
        md[c] = 7; mpend[c] = 0; mrun[c] = 0; mpos[c] = 0;
      end else if (!mrun[c]) begin
        if (load[c]) md[c] = clampv(v);
        if (en[c]) begin mrun[c] = 1; mpos[c] = 0; end
      end else if (mpos[c] == md[c] - 1) begin
        if (load[c]) begin md[c] = clampv(v); mpend[c] = 0; end
        else if (mpend[c]) begin md[c] = mp[c]; mpend[c] = 0; end
        mpos[c] = 0;
        mrun[c] = en[c];
      end else begin
        mpos[c]++;
        if (load[c]) begin mp[c] = clampv(v); mpend[c] = 1; end
      end
    end
  endtask

  // Output is high for the first D half-cycles of each 2D half-cycle period.
  task automatic check_half(input int h);
    for (int c = 0; c < CH; c++) begin
      logic eo;
      eo = mrun[c] && ((2 * mpos[c] + h) < md[c]);
      checks++;
      assert (out[c] === eo) else begin
        failures++;
        $error("FAIL out ch%0d half%0d got %b exp %b", c, h, out[c], eo);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_half(0);
    for (int c = 0; c < CH; c++) begin
      checks++;
      assert (tick[c] === mtick[c]) else begin
        failures++;
        $error("FAIL tick ch%0d got %b exp %b", c, tick[c], mtick[c]);
      end
    end
    @(negedge clk);
    #1;
    check_half(1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_load(input int c, input int v);
    div_in[c*W +: W] = W'(v);
    load[c] = 1'b1;
    cyc();
    load[c] = 1'b0;
  endtask

  task automatic run_until(input int c, input int p);
    int n;
    n = 0;
    while (!(mrun[c] && mpos[c] == p) && n < 300) begin
      cyc();
      n++;
    end
    checks++;
    assert (n < 300) else begin
      failures++;
      $error("FAIL timeout ch%0d pos %0d got %0d exp <300", c, p, n);
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; load = '0; div_in = '0;
    for (int c = 0; c < CH; c++) begin
      md[c] = 7; mp[c] = 7; mpend[c] = 0;
      mrun[c] = 0; mpos[c] = 0; mtick[c] = 0;
    end
    @(negedge clk);
    run(2);
    rst = 1'b0;
    en  = '1;
    run(22);
    run_until(0, 2);
    do_load(0, 4);
    run(20);
    run_until(0, 0);
    do_load(0, 5);
    run_until(0, 1);
    do_load(0, 9);
    run(25);
    run_until(0, 8);
    do_load(0, 6);
    run(15);
    run_until(0, 1);
    do_load(0, 0);
    run(10);
    do_load(0, 1);
    run(10);
    do_load(0, 8);
    run(6);
    run_until(0, 1);
    en[0] = 1'b0;
    run(20);
    en[0] = 1'b1;
    run(12);
    run_until(1, 3);
    do_load(1, 5);
    do_load(0, 3);
    run(12);
    run_until(1, 1);
    rst = 1'b1;
    en  = '1;
    load = '1;
    cyc();
    rst = 1'b0;
    load = '0;
    run(20);
    for (int k = 0; k < 500; k++) begin
      for (int c = 0; c < CH; c++) begin
        div_in[c*W +: W] = W'($urandom_range(0, 15));
        load[c] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
      end
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;
    load = '0;
    run(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
